// File: rtl/core_pkg.sv
// Shared encodings for the load/store unit: opcodes, funct3 widths, exception causes, FSM states.
package core_pkg;

    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {
        CauseLdMisalign = 2'd0,
        CauseStMisalign = 2'd1,
        CauseBusErr     = 2'd2,
        CauseIllegal    = 2'd3
    } exc_cause_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } lsu_state_e;

    // funct3[1:0] encodes access size for both loads and stores: 0 byte, 1 half, 2 word.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        unique case (f3[1:0])
            2'b00:   byte_enable = 4'b0001 << off;
            2'b01:   byte_enable = 4'b0011 << off;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_ldext.sv
// Load data lane extraction with sign or zero extension.
module core_lsu_ldext
    import core_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [31:0] shifted;

    assign shifted = i_rdata >> {i_addr, 3'b000};

    always_comb begin
        o_result = i_rdata;
        unique case (i_funct3)
            F3Byte:  o_result = {{24{shifted[7]}}, shifted[7:0]};
            F3Half:  o_result = {{16{shifted[15]}}, shifted[15:0]};
            F3ByteU: o_result = {24'd0, shifted[7:0]};
            F3HalfU: o_result = {16'd0, shifted[15:0]};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: single outstanding bus access, pass-through writeback for non-memory ops.
module core_lsu
    import core_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_res,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_rd,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_exc,
    output logic [1:0]      o_exc_cause,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [3:0]      o_bus_be,
    output logic [XLEN-1:0] o_bus_wdata,
    input  logic            i_bus_gnt,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_err
);

    lsu_state_e      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            store_q, store_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            exc_q, exc_d;
    exc_cause_e      cause_q, cause_d;

    logic            is_load, is_store, f3_ok, misaligned, timeout;
    logic [XLEN-1:0] ld_result;

    core_lsu_ldext u_ldext (
        .i_rdata  (i_bus_rdata),
        .i_addr   (off_q),
        .i_funct3 (f3_q),
        .o_result (ld_result)
    );

    assign is_load  = (i_opcode == OpcLoad);
    assign is_store = (i_opcode == OpcStore);
    assign f3_ok    = is_load ? (i_funct3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU})
                              : (i_funct3 inside {F3Byte, F3Half, F3Word});
    assign misaligned = ((i_funct3[1:0] == 2'b01) && i_res[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_res[1:0] != 2'b00));
    assign timeout  = (cnt_q == 8'(BUS_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        exc_d      = 1'b0;
        cause_d    = CauseLdMisalign;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    if (is_load || is_store) begin
                        if (!f3_ok) begin
                            exc_d   = 1'b1;
                            cause_d = CauseIllegal;
                        end else if (misaligned) begin
                            exc_d   = 1'b1;
                            cause_d = is_store ? CauseStMisalign : CauseLdMisalign;
                        end else begin
                            state_d = StReq;
                            store_d = is_store;
                            f3_d    = i_funct3;
                            off_d   = i_res[1:0];
                            rd_d    = i_rd;
                            addr_d  = {i_res[XLEN-1:2], 2'b00};
                            be_d    = byte_enable(i_funct3, i_res[1:0]);
                            unique case (i_funct3[1:0])
                                2'b00:   wdata_d = {4{i_wdata[7:0]}};
                                2'b01:   wdata_d = {2{i_wdata[15:0]}};
                                default: wdata_d = i_wdata;
                            endcase
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = i_rd;
                        wb_data_d  = i_res;
                    end
                end
            end
            StReq: begin
                if (i_bus_err || timeout) begin
                    exc_d   = 1'b1;
                    cause_d = CauseBusErr;
                    state_d = StIdle;
                end else if (i_bus_gnt) begin
                    state_d = store_q ? StIdle : StWait;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWait: begin
                if (i_bus_err || timeout) begin
                    exc_d   = 1'b1;
                    cause_d = CauseBusErr;
                    state_d = StIdle;
                end else if (i_bus_rvalid) begin
                    state_d = StResp;
                    if (rd_q != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_result;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            store_q    <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            exc_q      <= 1'b0;
            cause_q    <= CauseLdMisalign;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            store_q    <= store_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            exc_q      <= exc_d;
            cause_q    <= cause_d;
        end
    end

    // Bus fields read as zero whenever no request is outstanding.
    assign o_bus_req   = (state_q == StReq);
    assign o_bus_we    = o_bus_req & store_q;
    assign o_bus_addr  = o_bus_req ? addr_q : '0;
    assign o_bus_be    = o_bus_req ? be_q : '0;
    assign o_bus_wdata = o_bus_req ? wdata_q : '0;
    assign o_ready     = (state_q == StIdle);
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_rd     = wb_rd_q;
    assign o_wb_data   = wb_data_q;
    assign o_exc       = exc_q;
    assign o_exc_cause = cause_q;

endmodule

// File: tb/tb_core_lsu.sv
// Randomised self-checking bench for core_lsu against a byte-lane arithmetic model.
module tb_core_lsu;

    localparam int unsigned TO = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic clk = 1'b0;
    logic rst_n, valid, gnt, rvalid, err;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [31:0] res, wdata, rdata;
    logic [4:0] rd;
    logic ready, wb_valid, exc, bus_req, bus_we;
    logic [4:0] wb_rd;
    logic [31:0] wb_data, bus_addr, bus_wdata;
    logic [1:0] exc_cause;
    logic [3:0] bus_be;

    int n_tests = 0;
    int n_fail = 0;

    core_lsu #(.XLEN(32), .BUS_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_opcode(opcode), .i_funct3(funct3), .i_res(res), .i_wdata(wdata), .i_rd(rd),
        .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_exc(exc), .o_exc_cause(exc_cause),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_be(bus_be),
        .o_bus_wdata(bus_wdata),
        .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata), .i_bus_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Model: byte enables are a run of size ones shifted to the byte offset.
    function automatic logic [3:0] m_be(input int size, input int off);
        int v;
        v = ((1 << size) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] w);
        if (size == 1) return 32'(w[7:0]) * 32'h01010101;
        if (size == 2) return 32'(w[15:0]) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input int size, input bit sgn, input int off,
                                           input logic [31:0] word);
        longint span, lane;
        span = longint'(1) << (8 * size);
        lane = longint'(word >> (8 * off)) % span;
        if (sgn && lane >= span / 2) lane = lane - span;
        return lane[31:0];
    endfunction

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] r,
                         input logic [31:0] w, input logic [4:0] d);
        valid = 1'b1; opcode = op; funct3 = f3; res = r; wdata = w; rd = d;
        @(negedge clk);
        valid = 1'b0; opcode = '0; funct3 = '0; res = '0; wdata = '0; rd = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 0; opcode = 0; funct3 = 0; res = 0; wdata = 0; rd = 0;
        gnt = 0; rvalid = 0; err = 0; rdata = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({wb_valid, wb_rd, wb_data, exc, exc_cause, bus_req, bus_we, bus_addr, bus_be,
             bus_wdata, ready} !== {110'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b wb=%b exc=%b req=%b addr=%h, need all 0 ready=1",
                     ready, wb_valid, exc, bus_req, bus_addr);
        end
    endtask

    task automatic test_alu();
        logic [4:0] e_rd;
        logic [31:0] e_data;
        logic [6:0] op;
        issue(OP_ADD, 3'd0, 32'h1234, 32'h0, 5'd5);
        n_tests++;
        if ({wb_valid, wb_rd, wb_data, bus_req, exc} !== {1'b1, 5'd5, 32'h1234, 2'b00}) begin
            n_fail++;
            $display("FAIL alu_add: wb=%b rd=%0d data=%h req=%b, need 1 5 00001234 0",
                     wb_valid, wb_rd, wb_data, bus_req);
        end
        // Back-to-back: a new op every cycle, each result one cycle later.
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                n_tests++;
                if ({wb_valid, wb_rd, wb_data, ready, bus_req} !== {1'b1, e_rd, e_data, 2'b10}) begin
                    n_fail++;
                    $display("FAIL alu_b2b[%0d]: wb=%b rd=%0d data=%h, need 1 %0d %h",
                             i, wb_valid, wb_rd, wb_data, e_rd, e_data);
                end
            end
            if (i < 12) begin
                op = 7'($urandom);
                if (op == OP_LOAD || op == OP_STORE) op = OP_ADD;
                e_rd = 5'($urandom); e_data = $urandom;
                valid = 1'b1; opcode = op; funct3 = 3'($urandom); res = e_data; rd = e_rd;
                @(negedge clk);
            end
        end
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] w, input logic [2:0] f3,
                            input int size, input int dly);
        issue(OP_STORE, f3, addr, w, 5'($urandom));
        repeat (dly) @(negedge clk);
        n_tests++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, ready, wb_valid, exc} !==
            {2'b11, addr & 32'hFFFF_FFFC, m_be(size, int'(addr[1:0])), m_wdata(size, w), 3'b000})
        begin
            n_fail++;
            $display("FAIL store_req a=%h: req=%b we=%b addr=%h be=%b wd=%h, need be=%b wd=%h",
                     addr, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                     m_be(size, int'(addr[1:0])), m_wdata(size, w));
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        n_tests++;
        if ({bus_req, ready, wb_valid, exc} !== 4'b0100) begin
            n_fail++;
            $display("FAIL store_done a=%h: req=%b ready=%b wb=%b exc=%b, need 0 1 0 0",
                     addr, bus_req, ready, wb_valid, exc);
        end
    endtask

    task automatic test_store();
        int sz_tab[3] = '{1, 2, 4};
        int f, off;
        do_store(32'h1003, 32'h0000_00AB, 3'd0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            f = $urandom_range(0, 2);
            off = (f == 0) ? $urandom_range(0, 3) : (f == 1) ? 2 * $urandom_range(0, 1) : 0;
            do_store(($urandom & 32'hFFFF_FFFC) | 32'(off), $urandom, 3'(f), sz_tab[f],
                     $urandom_range(0, 2));
        end
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input int size,
                           input bit sgn, input logic [4:0] d, input logic [31:0] word,
                           input int gdly, input int rdly);
        logic [31:0] exp;
        exp = m_load(size, sgn, int'(addr[1:0]), word);
        issue(OP_LOAD, f3, addr, 32'($urandom), d);
        n_tests++;
        if ({bus_req, bus_we, bus_addr, bus_be, ready} !==
            {2'b10, addr & 32'hFFFF_FFFC, m_be(size, int'(addr[1:0])), 1'b0}) begin
            n_fail++;
            $display("FAIL load_req a=%h: req=%b we=%b addr=%h be=%b", addr, bus_req, bus_we,
                     bus_addr, bus_be);
        end
        repeat (gdly) @(negedge clk);
        // Stray rvalid alongside gnt must be ignored.
        gnt = 1'b1; rvalid = 1'($urandom); rdata = ~word;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b0;
        n_tests++;
        if ({bus_req, wb_valid, ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_wait a=%h: req=%b wb=%b ready=%b, need 0 0 0", addr, bus_req,
                     wb_valid, ready);
        end
        repeat (rdly) @(negedge clk);
        rvalid = 1'b1; rdata = word;
        @(negedge clk);
        rvalid = 1'b0; rdata = $urandom;
        n_tests++;
        if (d != 5'd0) begin
            if ({wb_valid, wb_rd, wb_data, exc} !== {1'b1, d, exp, 1'b0}) begin
                n_fail++;
                $display("FAIL load_wb a=%h f3=%0d word=%h: wb=%b rd=%0d data=%h, need 1 %0d %h",
                         addr, f3, word, wb_valid, wb_rd, wb_data, d, exp);
            end
        end else if ({wb_valid, exc} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_rd0 a=%h: wb=%b exc=%b, need 0 0", addr, wb_valid, exc);
        end
        @(negedge clk);
        n_tests++;
        if ({wb_valid, ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_end a=%h: wb=%b ready=%b, need 0 1", addr, wb_valid, ready);
        end
    endtask

    task automatic test_load();
        int f3_tab[5] = '{0, 1, 2, 4, 5};
        int sz_tab[5] = '{1, 2, 4, 1, 2};
        bit sg_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int k, off;
        do_load(32'h2002, 3'd0, 1, 1'b1, 5'd7, 32'h0080FF00, 0, 1);
        do_load(32'h2002, 3'd4, 1, 1'b0, 5'd7, 32'h0080FF00, 1, 0);
        do_load(32'h2000, 3'd2, 4, 1'b0, 5'd0, 32'hDEADBEEF, 0, 0);
        for (int i = 0; i < 15; i++) begin
            k = $urandom_range(0, 4);
            off = (sz_tab[k] == 1) ? $urandom_range(0, 3) :
                  (sz_tab[k] == 2) ? 2 * $urandom_range(0, 1) : 0;
            do_load(($urandom & 32'hFFFF_FFFC) | 32'(off), 3'(f3_tab[k]), sz_tab[k], sg_tab[k],
                    5'($urandom_range(1, 31)), $urandom, $urandom_range(0, 2),
                    $urandom_range(0, 2));
        end
    endtask

    task automatic test_exc_imm();
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] a;
        logic [1:0] cause;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin
                op = OP_LOAD; f3 = 3'd2; a = 32'h3002; cause = 2'd0;
            end else if (i == 1) begin
                op = OP_STORE; f3 = 3'd1; a = 32'h3001; cause = 2'd1;
            end else if (i < 8) begin
                op = ($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD;
                f3 = 3'($urandom_range(1, 2));
                a = $urandom & 32'hFFFF_FFFC;
                a[1:0] = (f3 == 3'd1) ? 2'(2 * $urandom_range(0, 1) + 1) : 2'($urandom_range(1, 3));
                cause = (op == OP_STORE) ? 2'd1 : 2'd0;
            end else begin
                op = ($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD;
                f3 = (op == OP_LOAD) ? ((i % 3 == 0) ? 3'd3 : 3'($urandom_range(6, 7)))
                                     : 3'($urandom_range(3, 7));
                a = $urandom & 32'hFFFF_FFFC;
                cause = 2'd3;
            end
            issue(op, f3, a, $urandom, 5'd9);
            n_tests++;
            if ({exc, exc_cause, bus_req, wb_valid, ready} !== {1'b1, cause, 3'b001}) begin
                n_fail++;
                $display("FAIL exc_imm op=%b f3=%0d a=%h: exc=%b cause=%0d req=%b wb=%b, need cause %0d",
                         op, f3, a, exc, exc_cause, bus_req, wb_valid, cause);
            end
            @(negedge clk);
            n_tests++;
            if ({exc, bus_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL exc_pulse a=%h: exc=%b req=%b, need 0 0", a, exc, bus_req);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        for (int mode = 0; mode < 3; mode++) begin
            issue(OP_LOAD, 3'd2, 32'h4000, 32'h0, 5'd3);
            if (mode != 1) begin
                gnt = 1'b1;
                @(negedge clk);
                gnt = 1'b0;
            end
            if (mode == 2) err = 1'b1;
            n = 0;
            while (exc !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            err = 1'b0;
            n_tests++;
            if (n !== ((mode == 2) ? 1 : int'(TO))) begin
                n_fail++;
                $display("FAIL timeout_cycles mode=%0d: waited %0d cycles, need %0d", mode, n,
                         (mode == 2) ? 1 : int'(TO));
            end
            n_tests++;
            if ({exc_cause, ready, bus_req, wb_valid} !== {2'd2, 3'b100}) begin
                n_fail++;
                $display("FAIL timeout_state mode=%0d: cause=%0d ready=%b req=%b, need 2 1 0",
                         mode, exc_cause, ready, bus_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        issue(OP_LOAD, 3'd2, 32'h5000, 32'h0, 5'd4);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        @(negedge clk);
        rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({wb_valid, wb_rd, wb_data, exc, exc_cause, bus_req, bus_we, bus_addr, bus_be,
                 bus_wdata, ready} !== {110'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: wb=%b exc=%b req=%b ready=%b, need 0 0 0 1",
                         i, wb_valid, exc, bus_req, ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_exc_imm();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
